// File: rtl/image_frame_scheduler_pkg.sv
// Shared types and constants for the image frame scheduler.
package image_sched_pkg;

    localparam int unsigned NUM_KEYS = 4;

    localparam int unsigned KEY_NEXT  = 0;
    localparam int unsigned KEY_PREV  = 1;
    localparam int unsigned KEY_FIRST = 2;
    localparam int unsigned KEY_SLIDE = 3;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        NAV_NONE,
        NAV_NEXT,
        NAV_PREV,
        NAV_FIRST
    } nav_e;

endpackage

// File: rtl/image_frame_scheduler_key_debounce.sv
// One board key: 2-FF synchronizer, stable-sample debouncer and a
// single-cycle press strobe on the debounced 1->0 (active-low) transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Level follows the synchronized key only after DEBOUNCE_CYC differing samples in a row.
    always_comb begin
        sync_d = {sync_q[0], key_i};
        db_d   = db_q;
        cnt_d  = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_d  = sync_q[1];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = db_q & ~db_d;
    end

    assign press_o = press_q;

endmodule

// File: rtl/image_frame_scheduler.sv
// Selects the displayed image and commits its framebuffer base at vblank start.
// Optional slideshow mode is compiled in with `define IMG_SCHED_SLIDESHOW_EN.
module image_frame_scheduler
    import image_sched_pkg::*;
#(
    parameter int unsigned       NUM_IMAGES   = 4,
    parameter int unsigned       IMG_STRIDE   = 307200,
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       DEBOUNCE_CYC = 500000,
    parameter int unsigned       SLIDE_FRAMES = 300
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [3:0]                    key_export,
    input  logic                          vga_vsync,
    output logic [ADDR_W-1:0]             img_base_addr,
    output logic [$clog2(NUM_IMAGES)-1:0] img_index,
    output logic                          swap_pulse,
    output logic                          slideshow_on,
    output logic                          pending
);

    localparam int unsigned       IDX_W     = $clog2(NUM_IMAGES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IMAGES - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(IMG_STRIDE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'((NUM_IMAGES - 1) * IMG_STRIDE);

    logic [NUM_KEYS-1:0] key_press;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_key (
            .clk_i  (clk_clk),
            .rst_i  (reset_reset),
            .key_i  (key_export[g]),
            .press_o(key_press[g])
        );
    end

    // vsync is registered once; vblank starts on the registered falling edge.
    logic vsync_q, vsync_prev_q;
    logic vblank_c;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            vsync_q      <= vga_vsync;
            vsync_prev_q <= vsync_q;
        end
    end

    assign vblank_c = vsync_prev_q & ~vsync_q;

    nav_e nav_c;
    logic manual_c;

    always_comb begin
        nav_c = NAV_NONE;
        if (key_press[KEY_FIRST]) begin
            nav_c = NAV_FIRST;
        end else if (key_press[KEY_PREV]) begin
            nav_c = NAV_PREV;
        end else if (key_press[KEY_NEXT]) begin
            nav_c = NAV_NEXT;
        end
    end

    assign manual_c = (nav_c != NAV_NONE);

    logic tick_c;

`ifdef IMG_SCHED_SLIDESHOW_EN
    localparam int unsigned SF_W = $clog2(SLIDE_FRAMES + 1);

    logic            slide_on_q, slide_on_d;
    logic [SF_W-1:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            slide_on_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            slide_on_q  <= slide_on_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Manual navigation and toggles restart the frame count; a tick needs neither.
    always_comb begin
        slide_on_d  = slide_on_q;
        frame_cnt_d = frame_cnt_q;
        tick_c      = 1'b0;
        if (key_press[KEY_SLIDE]) begin
            slide_on_d = ~slide_on_q;
        end
        if (manual_c || key_press[KEY_SLIDE]) begin
            frame_cnt_d = '0;
        end else if (slide_on_q && vblank_c) begin
            if (frame_cnt_q == SF_W'(SLIDE_FRAMES - 1)) begin
                tick_c      = 1'b1;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + SF_W'(1);
            end
        end
    end

    assign slideshow_on = slide_on_q;
`else
    logic [32:0] slide_unused;

    assign slide_unused = {key_press[KEY_SLIDE], 32'(SLIDE_FRAMES)};
    assign tick_c       = 1'b0;
    assign slideshow_on = 1'b0;
`endif

    nav_e ev_c;

    assign ev_c = manual_c ? nav_c : (tick_c ? NAV_NEXT : NAV_NONE);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    tgt_idx_q, tgt_idx_d;
    logic [ADDR_W-1:0]   tgt_addr_q, tgt_addr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                swap_q, swap_d;
    logic                pending_q, pending_d;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            tgt_idx_q  <= '0;
            tgt_addr_q <= BASE_ADDR;
            idx_q      <= '0;
            addr_q     <= BASE_ADDR;
            swap_q     <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_idx_q  <= tgt_idx_d;
            tgt_addr_q <= tgt_addr_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            swap_q     <= swap_d;
            pending_q  <= pending_d;
        end
    end

    // Target tracks events incrementally; the FSM copies it out at vblank.
    always_comb begin
        state_d    = state_q;
        tgt_idx_d  = tgt_idx_q;
        tgt_addr_d = tgt_addr_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        swap_d     = 1'b0;
        pending_d  = pending_q;

        unique case (ev_c)
            NAV_NEXT: begin
                if (tgt_idx_q == LAST_IDX) begin
                    tgt_idx_d  = '0;
                    tgt_addr_d = BASE_ADDR;
                end else begin
                    tgt_idx_d  = tgt_idx_q + IDX_W'(1);
                    tgt_addr_d = tgt_addr_q + STRIDE_A;
                end
            end
            NAV_PREV: begin
                if (tgt_idx_q == '0) begin
                    tgt_idx_d  = LAST_IDX;
                    tgt_addr_d = LAST_ADDR;
                end else begin
                    tgt_idx_d  = tgt_idx_q - IDX_W'(1);
                    tgt_addr_d = tgt_addr_q - STRIDE_A;
                end
            end
            NAV_FIRST: begin
                tgt_idx_d  = '0;
                tgt_addr_d = BASE_ADDR;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                // An event coinciding with vblank start rides this vblank.
                if (ev_c != NAV_NONE) begin
                    state_d   = vblank_c ? COMMIT : PEND;
                    pending_d = ~vblank_c;
                end
            end
            PEND: begin
                if (vblank_c) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                idx_d  = tgt_idx_q;
                addr_d = tgt_addr_q;
                swap_d = 1'b1;
                if (ev_c != NAV_NONE) begin
                    state_d   = PEND;
                    pending_d = 1'b1;
                end else begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    assign img_index     = idx_q;
    assign img_base_addr = addr_q;
    assign swap_pulse    = swap_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_image_frame_scheduler.sv
// Directed bench for image_frame_scheduler with short debounce and slideshow periods.
module tb_image_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  keys = 4'hF;
    logic        vsync = 1'b1;
    logic [31:0] addr;
    logic [1:0]  idx;
    logic        swap;
    logic        slide_on;
    logic        pend;

    int n_tests = 0;
    int n_fail  = 0;

    image_frame_scheduler #(
        .NUM_IMAGES  (4),
        .IMG_STRIDE  (307200),
        .ADDR_W      (32),
        .BASE_ADDR   (32'h0000_0000),
        .DEBOUNCE_CYC(4),
        .SLIDE_FRAMES(3)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .key_export   (keys),
        .vga_vsync    (vsync),
        .img_base_addr(addr),
        .img_index    (idx),
        .swap_pulse   (swap),
        .slideshow_on (slide_on),
        .pending      (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        bit          vs;
        logic [1:0]  exp_idx;
        logic [31:0] exp_addr;
        int          exp_swaps;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask);
        keys = ~mask;
        cyc(10);
        keys = 4'hF;
        cyc(10);
    endtask

    // Drive one vsync falling edge; report swap count and cycle of the first swap.
    task automatic vsync_edge(output int nswap, output int first_at);
        nswap    = 0;
        first_at = -1;
        vsync    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (swap === 1'b1) begin
                nswap++;
                if (first_at < 0) first_at = k;
            end
        end
        vsync = 1'b1;
        cyc(4);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        int ns;
        int fa;

        vecs[0]  = '{4'b0001, 1'b1, 2'd1, 32'd307200, 1};
        vecs[1]  = '{4'b0010, 1'b1, 2'd0, 32'd0,      1};
        vecs[2]  = '{4'b0010, 1'b1, 2'd3, 32'd921600, 1};
        vecs[3]  = '{4'b0001, 1'b1, 2'd0, 32'd0,      1};
        vecs[4]  = '{4'b0001, 1'b0, 2'd0, 32'd0,      0};
        vecs[5]  = '{4'b0001, 1'b0, 2'd0, 32'd0,      0};
        vecs[6]  = '{4'b0110, 1'b1, 2'd0, 32'd0,      1};
        vecs[7]  = '{4'b0010, 1'b0, 2'd0, 32'd0,      0};
        vecs[8]  = '{4'b0010, 1'b1, 2'd2, 32'd614400, 1};
        vecs[9]  = '{4'b0001, 1'b0, 2'd2, 32'd614400, 0};
        vecs[10] = '{4'b0010, 1'b1, 2'd2, 32'd614400, 1};
        vecs[11] = '{4'b0100, 1'b1, 2'd0, 32'd0,      1};

        cyc(1);
        do_reset(3);
        cyc(2);
        check("reset_idx", 64'(idx), 64'd0);
        check("reset_addr", 64'(addr), 64'd0);
        check("reset_swap", 64'(swap), 64'd0);
        check("reset_pending", 64'(pend), 64'd0);
        check("reset_slide", 64'(slide_on), 64'd0);

        for (int i = 0; i < 12; i++) begin
            press(vecs[i].mask);
            check($sformatf("v%0d_pending_before", i), 64'(pend), 64'd1);
            if (vecs[i].vs) begin
                vsync_edge(ns, fa);
                check($sformatf("v%0d_swaps", i), 64'(ns), 64'(vecs[i].exp_swaps));
                check($sformatf("v%0d_swap_latency", i), 64'(fa), 64'd2);
                check($sformatf("v%0d_pending_after", i), 64'(pend), 64'd0);
            end
            check($sformatf("v%0d_idx", i), 64'(idx), 64'(vecs[i].exp_idx));
            check($sformatf("v%0d_addr", i), 64'(addr), 64'(vecs[i].exp_addr));
        end

        // Bounce: KEY0 toggling every 2 cycles must never register.
        for (int t = 0; t < 10; t++) begin
            keys = 4'hE;
            cyc(2);
            keys = 4'hF;
            cyc(2);
        end
        cyc(10);
        check("bounce_pending", 64'(pend), 64'd0);
        check("bounce_idx", 64'(idx), 64'd0);

`ifdef IMG_SCHED_SLIDESHOW_EN
        press(4'b1000);
        check("slide_on", 64'(slide_on), 64'd1);
        check("slide_toggle_pending", 64'(pend), 64'd0);
        for (int e = 1; e <= 5; e++) begin
            vsync_edge(ns, fa);
            check($sformatf("slide_e%0d_swaps", e), 64'(ns), (e == 3) ? 64'd1 : 64'd0);
            check($sformatf("slide_e%0d_idx", e), 64'(idx), (e >= 3) ? 64'd1 : 64'd0);
        end
        // Manual next lands in the same cycle as the slideshow tick: exactly +1.
        keys = 4'hE;
        cyc(5);
        vsync = 1'b0;
        ns = 0;
        fa = -1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (swap === 1'b1) begin
                ns++;
                if (fa < 0) fa = k;
            end
        end
        keys  = 4'hF;
        vsync = 1'b1;
        cyc(10);
        check("slide_manual_swaps", 64'(ns), 64'd1);
        check("slide_manual_latency", 64'(fa), 64'd2);
        check("slide_manual_idx", 64'(idx), 64'd2);
        check("slide_manual_addr", 64'(addr), 64'd614400);
        check("slide_manual_pending", 64'(pend), 64'd0);
`else
        press(4'b1000);
        check("slide_off_on", 64'(slide_on), 64'd0);
        check("slide_off_pending", 64'(pend), 64'd0);
        for (int e = 1; e <= 3; e++) begin
            vsync_edge(ns, fa);
            check($sformatf("slide_off_e%0d_swaps", e), 64'(ns), 64'd0);
        end
        check("slide_off_idx", 64'(idx), 64'd0);
`endif

        // Reset while a target is pending discards it.
        do_reset(2);
        check("rst2_idx", 64'(idx), 64'd0);
        check("rst2_slide", 64'(slide_on), 64'd0);
        press(4'b0001);
        vsync_edge(ns, fa);
        check("pre_rst_idx", 64'(idx), 64'd1);
        press(4'b0001);
        check("pre_rst_pending", 64'(pend), 64'd1);
        do_reset(1);
        check("mid_rst_pending", 64'(pend), 64'd0);
        check("mid_rst_idx", 64'(idx), 64'd0);
        check("mid_rst_addr", 64'(addr), 64'd0);
        vsync_edge(ns, fa);
        check("post_rst_swaps", 64'(ns), 64'd0);
        check("post_rst_idx", 64'(idx), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
